kgp_mc_ctrl: RTL and testbench



---
 rtl/kgp_mc_ctrl_pkg.sv | 30 +++
 rtl/kgp_mc_ctrl_if.sv | 43 ++++
 rtl/kgp_mc_ctrl_perf_ctr.sv | 29 ++
 rtl/kgp_mc_ctrl.sv | 146 ++++++++++++++
 tb/tb_kgp_mc_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/kgp_mc_ctrl_pkg.sv
// Shared constants for the KGP multi-cycle controller: instruction classes,
// FSM state encodings and register-file write selects.
package kgp_ctrl_pkg;

   // Instruction classes as produced by the decoder
   localparam logic [2:0] CLS_ALU_R  = 3'd0;
   localparam logic [2:0] CLS_ALU_I  = 3'd1;
   localparam logic [2:0] CLS_LOAD   = 3'd2;
   localparam logic [2:0] CLS_STORE  = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;
   localparam logic [2:0] CLS_CALL   = 3'd5;
   localparam logic [2:0] CLS_HALT   = 3'd6;
   localparam logic [2:0] CLS_NOP    = 3'd7;

   // Controller states (legacy binary encoding)
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_FETCH  = 3'd1;
   localparam logic [2:0] ST_DECODE = 3'd2;
   localparam logic [2:0] ST_EXEC   = 3'd3;
   localparam logic [2:0] ST_MEM    = 3'd4;
   localparam logic [2:0] ST_WB     = 3'd5;
   localparam logic [2:0] ST_HALTED = 3'd6;

   // Register-file write select
   localparam logic [1:0] RW_NONE = 2'b00;
   localparam logic [1:0] RW_RS   = 2'b01;
   localparam logic [1:0] RW_RT   = 2'b10;
   localparam logic [1:0] RW_R31  = 2'b11;

endpackage

// File: rtl/kgp_mc_ctrl_if.sv
// Control bus between decoder/datapath and the KGP multi-cycle controller.
// master: decoder/datapath side; slave: the controller.
// Optional macro KGP_CTRL_PERF_EN adds the instret/cycles counter outputs.
interface kgp_mc_ctrl_if #(
   parameter int CLASS_W = 3
) ();
   logic               start;
   logic [CLASS_W-1:0] instr_class;
   logic               branch_taken;
   logic               mem_ack;
   logic               mem_read;
   logic               mem_write;
   logic               ir_write;
   logic               pc_write;
   logic               pc_src;
   logic               alu_en;
   logic [1:0]         reg_write;
   logic               busy;
   logic               halted;
   logic               retire;
`ifdef KGP_CTRL_PERF_EN
   logic [31:0]        instret;
   logic [31:0]        cycles;
`endif

   modport master (
      output start, instr_class, branch_taken, mem_ack,
      input  mem_read, mem_write, ir_write, pc_write, pc_src, alu_en,
             reg_write, busy, halted, retire
`ifdef KGP_CTRL_PERF_EN
      , input instret, cycles
`endif
   );

   modport slave (
      input  start, instr_class, branch_taken, mem_ack,
      output mem_read, mem_write, ir_write, pc_write, pc_src, alu_en,
             reg_write, busy, halted, retire
`ifdef KGP_CTRL_PERF_EN
      , output instret, cycles
`endif
   );
endinterface

// File: rtl/kgp_mc_ctrl_perf_ctr.sv
// kgp_perf_ctr: enable-gated wrapping counter used for the controller's
// performance outputs. Only built when KGP_CTRL_PERF_EN is defined.
`ifdef KGP_CTRL_PERF_EN
module kgp_perf_ctr #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: increment when enabled, wrapping naturally at 2^W
   always_comb begin
      count_d = count_q;
      if (en_i) count_d = count_q + 1'b1;
   end

   // Count register, cleared by asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count_o = count_q;
endmodule
`endif

// File: rtl/kgp_mc_ctrl.sv
// KGP mini-RISC multi-cycle controller: fetch/decode/exec/mem/wb sequencing.
// The state register is the only storage; instr_class is read live in every
// state from DECODE onward. Optional macro KGP_CTRL_PERF_EN adds counters.
module kgp_mc_ctrl
   import kgp_ctrl_pkg::*;
#(
   parameter int CLASS_W = 3
) (
   input logic          clk,
   input logic          rst,
   kgp_mc_ctrl_if.slave bus
);
   logic [2:0] state_q;
   logic [2:0] state_d;

   logic       mem_read_d, mem_write_d, ir_write_d, pc_write_d, pc_src_d;
   logic       alu_en_d, halted_d, retire_d;
   logic [1:0] reg_write_d;

   logic is_alu, is_load, is_store, is_branch, is_call, is_halt, is_nop;

   assign is_alu    = (bus.instr_class == CLASS_W'(CLS_ALU_R)) ||
                      (bus.instr_class == CLASS_W'(CLS_ALU_I));
   assign is_load   = (bus.instr_class == CLASS_W'(CLS_LOAD));
   assign is_store  = (bus.instr_class == CLASS_W'(CLS_STORE));
   assign is_branch = (bus.instr_class == CLASS_W'(CLS_BRANCH));
   assign is_call   = (bus.instr_class == CLASS_W'(CLS_CALL));
   assign is_halt   = (bus.instr_class == CLASS_W'(CLS_HALT));
   assign is_nop    = (bus.instr_class == CLASS_W'(CLS_NOP));

   // Next-state and Mealy/Moore output decode
   always_comb begin
      state_d     = state_q;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      ir_write_d  = 1'b0;
      pc_write_d  = 1'b0;
      pc_src_d    = 1'b0;
      alu_en_d    = 1'b0;
      reg_write_d = RW_NONE;
      halted_d    = 1'b0;
      retire_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            mem_read_d = 1'b1;
            if (bus.mem_ack) begin
               ir_write_d = 1'b1;
               pc_write_d = 1'b1;
               state_d    = ST_DECODE;
            end
         end
         ST_DECODE: begin
            if (is_halt) begin
               state_d = ST_HALTED;
            end else if (is_nop || !(is_alu || is_load || is_store || is_branch || is_call)) begin
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            alu_en_d = 1'b1;
            if (is_alu) begin
               state_d = ST_WB;
            end else if (is_load || is_store) begin
               state_d = ST_MEM;
            end else if (is_call) begin
               pc_write_d = 1'b1;
               pc_src_d   = 1'b1;
               state_d    = ST_WB;
            end else begin
               // BRANCH, or a class that changed after DECODE: finish here
               pc_write_d = is_branch && bus.branch_taken;
               pc_src_d   = is_branch && bus.branch_taken;
               retire_d   = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         ST_MEM: begin
            if (is_load) begin
               mem_read_d = 1'b1;
               if (bus.mem_ack) state_d = ST_WB;
            end else if (is_store) begin
               mem_write_d = 1'b1;
               if (bus.mem_ack) begin
                  retire_d = 1'b1;
                  state_d  = ST_FETCH;
               end
            end else begin
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         ST_WB: begin
            if (is_alu)       reg_write_d = RW_RS;
            else if (is_load) reg_write_d = RW_RT;
            else if (is_call) reg_write_d = RW_R31;
            retire_d = 1'b1;
            state_d  = ST_FETCH;
         end
         ST_HALTED: begin
            halted_d = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register; async reset forces IDLE so all outputs drop at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   assign bus.mem_read  = mem_read_d;
   assign bus.mem_write = mem_write_d;
   assign bus.ir_write  = ir_write_d;
   assign bus.pc_write  = pc_write_d;
   assign bus.pc_src    = pc_src_d;
   assign bus.alu_en    = alu_en_d;
   assign bus.reg_write = reg_write_d;
   assign bus.halted    = halted_d;
   assign bus.retire    = retire_d;
   assign bus.busy      = (state_q != ST_IDLE) && (state_q != ST_HALTED);

`ifdef KGP_CTRL_PERF_EN
   kgp_perf_ctr #(.W(32)) u_instret (
      .clk     (clk),
      .rst     (rst),
      .en_i    (retire_d),
      .count_o (bus.instret)
   );

   kgp_perf_ctr #(.W(32)) u_cycles (
      .clk     (clk),
      .rst     (rst),
      .en_i    (bus.busy),
      .count_o (bus.cycles)
   );
`endif
endmodule

// File: tb/tb_kgp_mc_ctrl.sv
// Directed table-driven bench for kgp_mc_ctrl, plus hand-written sequences
// for asynchronous reset in WB and (with KGP_CTRL_PERF_EN) the counters.
module tb_kgp_mc_ctrl;
   import kgp_ctrl_pkg::*;

   // Observed output bit positions
   localparam logic [10:0] MR   = 11'h400;
   localparam logic [10:0] MW   = 11'h200;
   localparam logic [10:0] IRW  = 11'h100;
   localparam logic [10:0] PCW  = 11'h080;
   localparam logic [10:0] PCS  = 11'h040;
   localparam logic [10:0] ALU  = 11'h020;
   localparam logic [10:0] RWRS = 11'h008;
   localparam logic [10:0] RWRT = 11'h010;
   localparam logic [10:0] RW31 = 11'h018;
   localparam logic [10:0] BSY  = 11'h004;
   localparam logic [10:0] HLT  = 11'h002;
   localparam logic [10:0] RET  = 11'h001;
   localparam logic [10:0] NONE = 11'h000;
   localparam logic [10:0] FOK  = MR | IRW | PCW | BSY;

   typedef struct {
      logic        rst;
      logic        start;
      logic [2:0]  cls;
      logic        bt;
      logic        ack;
      logic [10:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   nvec  = 0;
   int   nfail = 0;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   kgp_mc_ctrl_if #(.CLASS_W(3)) bus ();

   kgp_mc_ctrl #(.CLASS_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [10:0] obs;
   assign obs = {bus.mem_read, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
                 bus.alu_en, bus.reg_write, bus.busy, bus.halted, bus.retire};

   function automatic void add(input logic r, input logic s, input logic [2:0] c,
                               input logic b, input logic a, input logic [10:0] e);
      vec_t v;
      v.rst = r; v.start = s; v.cls = c; v.bt = b; v.ack = a; v.exp = e;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic [2:0] c,
                        input logic b, input logic a);
      rst = r; bus.start = s; bus.instr_class = c; bus.branch_taken = b; bus.mem_ack = a;
   endtask

   // One cycle: drive after the rising edge, compare on the falling edge
   task automatic step(input vec_t v, input string name);
      @(posedge clk); #1;
      drive(v.rst, v.start, v.cls, v.bt, v.ack);
      @(negedge clk);
      chk(name, {21'd0, obs}, {21'd0, v.exp});
   endtask

   task automatic fill;
      // reset, then first cycle after release
      add(1, 0, 0, 0, 0, NONE);
      add(1, 1, 0, 0, 1, NONE);
      add(0, 0, 0, 0, 1, NONE);
      // ALU_R, zero-wait: FETCH c1, WB c4, FETCH again c5
      add(0, 1, CLS_ALU_R, 0, 0, NONE);
      add(0, 0, CLS_ALU_R, 0, 1, FOK);
      add(0, 1, CLS_ALU_R, 0, 1, BSY);
      add(0, 0, CLS_ALU_R, 0, 1, ALU | BSY);
      add(0, 0, CLS_ALU_R, 0, 1, RWRS | BSY | RET);
      // LOAD: one fetch wait, then ack delayed 2 cycles in MEM
      add(0, 0, CLS_LOAD, 0, 0, MR | BSY);
      add(0, 0, CLS_LOAD, 0, 1, FOK);
      add(0, 0, CLS_LOAD, 0, 1, BSY);
      add(0, 0, CLS_LOAD, 0, 1, ALU | BSY);
      add(0, 0, CLS_LOAD, 0, 0, MR | BSY);
      add(0, 0, CLS_LOAD, 0, 0, MR | BSY);
      add(0, 0, CLS_LOAD, 0, 1, MR | BSY);
      add(0, 0, CLS_LOAD, 0, 1, RWRT | BSY | RET);
      // BRANCH taken
      add(0, 0, CLS_BRANCH, 1, 1, FOK);
      add(0, 0, CLS_BRANCH, 1, 0, BSY);
      add(0, 0, CLS_BRANCH, 1, 0, ALU | PCW | PCS | BSY | RET);
      // BRANCH not taken
      add(0, 0, CLS_BRANCH, 0, 1, FOK);
      add(0, 0, CLS_BRANCH, 0, 0, BSY);
      add(0, 0, CLS_BRANCH, 0, 0, ALU | BSY | RET);
      // CALL
      add(0, 0, CLS_CALL, 0, 1, FOK);
      add(0, 0, CLS_CALL, 0, 0, BSY);
      add(0, 0, CLS_CALL, 0, 0, ALU | PCW | PCS | BSY);
      add(0, 0, CLS_CALL, 0, 0, RW31 | BSY | RET);
      // STORE with one MEM wait
      add(0, 0, CLS_STORE, 0, 1, FOK);
      add(0, 0, CLS_STORE, 0, 0, BSY);
      add(0, 0, CLS_STORE, 0, 1, ALU | BSY);
      add(0, 0, CLS_STORE, 0, 0, MW | BSY);
      add(0, 0, CLS_STORE, 0, 1, MW | BSY | RET);
      // ALU_I then NOP
      add(0, 0, CLS_ALU_I, 0, 1, FOK);
      add(0, 0, CLS_ALU_I, 0, 0, BSY);
      add(0, 0, CLS_ALU_I, 0, 0, ALU | BSY);
      add(0, 0, CLS_ALU_I, 0, 0, RWRS | BSY | RET);
      add(0, 0, CLS_NOP, 0, 1, FOK);
      add(0, 0, CLS_NOP, 0, 0, BSY | RET);
      // HALT, then toggle start/ack: no change; rst clears
      add(0, 0, CLS_HALT, 0, 1, FOK);
      add(0, 0, CLS_HALT, 0, 0, BSY);
      for (int i = 0; i < 10; i++)
         add(0, i[0], CLS_ALU_R, 1, ~i[0], HLT);
      add(1, 0, 0, 0, 0, NONE);
      add(0, 0, 0, 0, 0, NONE);
      // reset asserted in WB of ALU_R drops everything in that cycle
      add(0, 1, CLS_ALU_R, 0, 0, NONE);
      add(0, 0, CLS_ALU_R, 0, 1, FOK);
      add(0, 0, CLS_ALU_R, 0, 0, BSY);
      add(0, 0, CLS_ALU_R, 0, 0, ALU | BSY);
      add(1, 0, CLS_ALU_R, 0, 0, NONE);
      add(0, 0, CLS_ALU_R, 0, 1, NONE);
   endtask

   initial begin
      drive(1, 0, 0, 0, 0);
      fill();
      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i], $sformatf("vec%0d", i));

      // Reset pulsed mid-cycle while in WB: reg_write must drop at once
      step('{0, 1, CLS_ALU_R, 0, 0, NONE}, "wbrst_idle");
      step('{0, 0, CLS_ALU_R, 0, 1, FOK}, "wbrst_fetch");
      step('{0, 0, CLS_ALU_R, 0, 0, BSY}, "wbrst_dec");
      step('{0, 0, CLS_ALU_R, 0, 0, ALU | BSY}, "wbrst_exec");
      step('{0, 0, CLS_ALU_R, 0, 0, RWRS | BSY | RET}, "wbrst_wb");
      #1 rst = 1'b1;
      #1 chk("wbrst_async", {21'd0, obs}, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("wbrst_after", {21'd0, obs}, 32'd0);
      step('{0, 1, CLS_ALU_R, 0, 0, NONE}, "wbrst_start");
      step('{0, 0, CLS_ALU_R, 0, 0, MR | BSY}, "wbrst_refetch");

`ifdef KGP_CTRL_PERF_EN
      step('{1, 0, CLS_ALU_R, 0, 1, NONE}, "perf_rst");
      step('{0, 1, CLS_ALU_R, 0, 1, NONE}, "perf_start");
      for (int n = 0; n < 3; n++) begin
         step('{0, 0, CLS_ALU_R, 0, 1, FOK}, "perf_f");
         step('{0, 0, CLS_ALU_R, 0, 1, BSY}, "perf_d");
         step('{0, 0, CLS_ALU_R, 0, 1, ALU | BSY}, "perf_e");
         step('{0, 0, CLS_ALU_R, 0, 1, RWRS | BSY | RET}, "perf_wb");
      end
      step('{0, 0, CLS_ALU_R, 0, 0, MR | BSY}, "perf_f4");
      chk("instret", bus.instret, 32'd3);
      chk("cycles", bus.cycles, 32'd12);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end
endmodule
